ddr3_arb: RTL and testbench

Read/write request arbiter placed between the AXI-side read and write command queues and the DDR3 command FSM's read and write ports. It grants one direction at a time and locks the grant until the LAST burst of the current sequence has been acknowledged. The FSM therefore never sees both `mem_rdreq_o` and `mem_wrreq_o` asserted. Selection bounds run length per direction for fairness and orders a same-address write ahead of a read.

---
 rtl/ddr3_arb.sv | 140 ++++++++++++++
 tb/tb_ddr3_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_arb.sv
// ddr3_arb: read/write arbiter in front of the DDR3 command FSM.
// One direction is granted at a time, and the grant is held until the LAST beat
// of the current sequence is acknowledged. A run counter bounds how many
// consecutive same-direction sequences are granted while the other side waits,
// and a write to the same burst-aligned address is ordered ahead of a read.
module ddr3_arb #(
  parameter int REQID   = 4,
  parameter int ADDRS   = 23,
  parameter int MAX_RUN = 4
) (
  input  logic             clock,
  input  logic             reset,
  // read command queue
  input  logic             rd_req_i,
  input  logic             rd_lst_i,
  input  logic [REQID-1:0] rd_tid_i,
  input  logic [ADDRS-1:0] rd_adr_i,
  output logic             rd_ack_o,
  // write command queue
  input  logic             wr_req_i,
  input  logic             wr_lst_i,
  input  logic [REQID-1:0] wr_tid_i,
  input  logic [ADDRS-1:0] wr_adr_i,
  output logic             wr_ack_o,
  // DDR3 command FSM read port
  output logic             mem_rdreq_o,
  output logic             mem_rdlst_o,
  output logic [REQID-1:0] mem_rdtid_o,
  output logic [ADDRS-1:0] mem_rdadr_o,
  input  logic             mem_rdack_i,
  // DDR3 command FSM write port
  output logic             mem_wrreq_o,
  output logic             mem_wrlst_o,
  output logic [REQID-1:0] mem_wrtid_o,
  output logic [ADDRS-1:0] mem_wradr_o,
  input  logic             mem_wrack_i,
  // current grant
  output logic [1:0]       arb_dir_o
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RD   = 2'b01;
  localparam logic [1:0] ST_WR   = 2'b10;

  // Direction encoding for last_dir: 0 = read, 1 = write.
  localparam logic DIR_RD = 1'b0;

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_RUN);
  localparam logic [3:0] RUN_SAT   = 4'hF;

  logic [1:0] state_q, state_d;
  logic       last_dir_q, last_dir_d;
  logic [3:0] run_q, run_d;

  logic both_req;
  logic addr_hazard;
  logic pick_wr;
  logic rd_grant;
  logic wr_grant;

  assign both_req    = rd_req_i & wr_req_i;
  assign addr_hazard = (wr_adr_i[ADDRS-1:3] == rd_adr_i[ADDRS-1:3]);

  // Next-state selection: arbitrate in IDLE, hold the grant until LAST is acked.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    last_dir_d = last_dir_q;
    run_d      = run_q;
    pick_wr    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_req_i || wr_req_i) begin
          if (both_req) begin
            if (addr_hazard)             pick_wr = 1'b1;
            else if (run_q >= RUN_LIMIT) pick_wr = (last_dir_q == DIR_RD);
            else                         pick_wr = last_dir_q;
          end else begin
            pick_wr = wr_req_i;
          end
          state_d = pick_wr ? ST_WR : ST_RD;
          if (pick_wr == last_dir_q) begin
            run_d = (run_q == RUN_SAT) ? run_q : run_q + 4'd1;
          end else begin
            run_d      = 4'd1;
            last_dir_d = pick_wr;
          end
        end
      end
      ST_RD:   if (mem_rdack_i && rd_lst_i) state_d = ST_IDLE;
      ST_WR:   if (mem_wrack_i && wr_lst_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers; reset returns to IDLE with reads as the last direction.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_RD;
      run_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      run_q      <= run_d;
    end
  end

  assign rd_grant = (state_q == ST_RD);
  assign wr_grant = (state_q == ST_WR);

  // Request/LAST/ack are gated by the grant; tid/adr pass straight through.
  assign mem_rdreq_o = rd_grant & rd_req_i;
  assign mem_rdlst_o = rd_grant & rd_lst_i;
  assign mem_rdtid_o = rd_tid_i;
  assign mem_rdadr_o = rd_adr_i;
  assign rd_ack_o    = rd_grant & mem_rdack_i;

  assign mem_wrreq_o = wr_grant & wr_req_i;
  assign mem_wrlst_o = wr_grant & wr_lst_i;
  assign mem_wrtid_o = wr_tid_i;
  assign mem_wradr_o = wr_adr_i;
  assign wr_ack_o    = wr_grant & mem_wrack_i;

  assign arb_dir_o = state_q;

`ifdef __icarus
  // An ack on the port that does not hold the grant is a protocol error.
  always @(posedge clock) begin
    if (reset) begin
      assert (!(mem_rdack_i && !rd_grant));
      assert (!(mem_wrack_i && !wr_grant));
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_arb.sv
// Testbench for ddr3_arb: a vector table for read-only and contention traffic,
// plus hand-written sequences for hazard ordering, sequence lock, asynchronous
// reset and stray acks. The DUT runs with MAX_RUN = 2.
module tb_ddr3_arb;

  localparam int REQID = 4;
  localparam int ADDRS = 23;

  logic             clock;
  logic             reset;
  logic             rd_req_i, rd_lst_i, rd_ack_o;
  logic [REQID-1:0] rd_tid_i;
  logic [ADDRS-1:0] rd_adr_i;
  logic             wr_req_i, wr_lst_i, wr_ack_o;
  logic [REQID-1:0] wr_tid_i;
  logic [ADDRS-1:0] wr_adr_i;
  logic             mem_rdreq_o, mem_rdlst_o, mem_rdack_i;
  logic [REQID-1:0] mem_rdtid_o;
  logic [ADDRS-1:0] mem_rdadr_o;
  logic             mem_wrreq_o, mem_wrlst_o, mem_wrack_i;
  logic [REQID-1:0] mem_wrtid_o;
  logic [ADDRS-1:0] mem_wradr_o;
  logic [1:0]       arb_dir_o;

  ddr3_arb #(.REQID(REQID), .ADDRS(ADDRS), .MAX_RUN(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .rd_req_i    (rd_req_i),
    .rd_lst_i    (rd_lst_i),
    .rd_tid_i    (rd_tid_i),
    .rd_adr_i    (rd_adr_i),
    .rd_ack_o    (rd_ack_o),
    .wr_req_i    (wr_req_i),
    .wr_lst_i    (wr_lst_i),
    .wr_tid_i    (wr_tid_i),
    .wr_adr_i    (wr_adr_i),
    .wr_ack_o    (wr_ack_o),
    .mem_rdreq_o (mem_rdreq_o),
    .mem_rdlst_o (mem_rdlst_o),
    .mem_rdtid_o (mem_rdtid_o),
    .mem_rdadr_o (mem_rdadr_o),
    .mem_rdack_i (mem_rdack_i),
    .mem_wrreq_o (mem_wrreq_o),
    .mem_wrlst_o (mem_wrlst_o),
    .mem_wrtid_o (mem_wrtid_o),
    .mem_wradr_o (mem_wradr_o),
    .mem_wrack_i (mem_wrack_i),
    .arb_dir_o   (arb_dir_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed outputs: {dir[1:0], mrq, mrl, mwq, mwl, rack, wack}.
  logic [7:0] obs;
  assign obs = {arb_dir_o, mem_rdreq_o, mem_rdlst_o, mem_wrreq_o, mem_wrlst_o, rd_ack_o, wr_ack_o};

  localparam logic [7:0] E_IDLE  = 8'b00_000000;
  localparam logic [7:0] E_RD    = 8'b01_100010; // read beat acked, not LAST
  localparam logic [7:0] E_RDL   = 8'b01_110010; // read LAST beat acked
  localparam logic [7:0] E_WR    = 8'b10_001001; // write beat acked, not LAST
  localparam logic [7:0] E_WRL   = 8'b10_001101; // write LAST beat acked

  typedef struct {
    bit         rst;
    logic       rr, rl, wr, wl, ra, wa;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, logic rr, logic rl, logic wr, logic wl,
                              logic ra, logic wa, logic [7:0] exp, string name);
    vec_t v;
    v.rst = rst; v.rr = rr; v.rl = rl; v.wr = wr; v.wl = wl;
    v.ra = ra; v.wa = wa; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic drive(logic rr, logic rl, logic wr, logic wl, logic ra, logic wa);
    rd_req_i = rr; rd_lst_i = rl; wr_req_i = wr; wr_lst_i = wl;
    mem_rdack_i = ra; mem_wrack_i = wa;
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic cyc_check(input string name, input logic [7:0] exp);
    @(negedge clock);
    check(name, 32'(obs), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    rd_adr_i = 23'h000010;
    wr_adr_i = 23'h000020;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    rd_tid_i = 4'hA;
    wr_tid_i = 4'h5;
    rd_adr_i = 23'h000010;
    wr_adr_i = 23'h000020;
    // Requests and acks active during reset must not leak through.
    drive(1, 1, 1, 1, 1, 1);
    #3;
    check("reset_outputs", 32'(obs), 32'(E_IDLE));
    check("rd_tid_pass", 32'(mem_rdtid_o), 32'h0000000A);
    check("wr_adr_pass", 32'(mem_wradr_o), 32'h00000020);

    // Read-only: 3-beat sequence, LAST on beat 3, then one IDLE cycle.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, E_IDLE, "ro_idle"));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, E_RD,   "ro_beat1"));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, E_RD,   "ro_beat2"));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, E_RDL,  "ro_beat3"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_IDLE, "ro_after"));
    // Contention, MAX_RUN=2, 1-beat LAST sequences: RD RD WR WR RD RD WR.
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, E_IDLE, "ct_i0"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, E_RDL,  "ct_rd1"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, E_IDLE, "ct_i1"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, E_RDL,  "ct_rd2"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, E_IDLE, "ct_i2"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, E_WRL,  "ct_wr1"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, E_IDLE, "ct_i3"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, E_WRL,  "ct_wr2"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, E_IDLE, "ct_i4"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, E_RDL,  "ct_rd3"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, E_IDLE, "ct_i5"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, E_RDL,  "ct_rd4"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, E_IDLE, "ct_i6"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, E_WRL,  "ct_wr3"));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].rr, vecs[i].rl, vecs[i].wr, vecs[i].wl, vecs[i].ra, vecs[i].wa);
      cyc_check(vecs[i].name, vecs[i].exp);
    end

    // Hazard: same burst address, both pending, last_dir=RD, run=0 -> write first.
    do_reset();
    rd_adr_i = 23'h01A208;
    wr_adr_i = 23'h01A208;
    drive(1, 1, 1, 1, 0, 0);
    cyc_check("hz_idle0", E_IDLE);
    drive(1, 1, 1, 1, 0, 1);
    cyc_check("hz_wr", E_WRL);
    drive(1, 1, 0, 0, 0, 0);
    cyc_check("hz_idle1", E_IDLE);
    drive(1, 1, 0, 0, 1, 0);
    cyc_check("hz_rd", E_RDL);

    // Sequence lock: read arrives at write beat 2, waits for LAST plus IDLE.
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    cyc_check("lk_idle0", E_IDLE);
    drive(0, 0, 1, 0, 0, 1);
    cyc_check("lk_beat1", E_WR);
    drive(1, 1, 1, 0, 0, 1);
    cyc_check("lk_beat2", E_WR);
    cyc_check("lk_beat3", E_WR);
    drive(1, 1, 1, 1, 0, 1);
    cyc_check("lk_beat4", E_WRL);
    drive(1, 1, 0, 0, 0, 0);
    cyc_check("lk_idle1", E_IDLE);
    drive(1, 1, 0, 0, 1, 0);
    cyc_check("lk_rd", E_RDL);

    // Reset asserted during read beat 2: outputs clear at once, write wins after.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    cyc_check("rs_idle0", E_IDLE);
    drive(1, 0, 0, 0, 1, 0);
    cyc_check("rs_beat1", E_RD);
    reset = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    #1;
    check("rs_async_clear", 32'(obs), 32'(E_IDLE));
    #2;
    reset = 1'b1;
    cyc_check("rs_idle1", E_IDLE);
    drive(0, 0, 1, 1, 0, 1);
    cyc_check("rs_wr", E_WRL);

    // Stray write ack during a read grant: ignored, grant and run unchanged.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    cyc_check("sa_idle0", E_IDLE);
    drive(1, 0, 0, 1, 0, 1);
    cyc_check("sa_stray", 8'b01_100000);
    drive(1, 0, 0, 0, 0, 0);
    cyc_check("sa_held", 8'b01_100000);
    drive(1, 1, 0, 0, 1, 0);
    cyc_check("sa_rdlast", E_RDL);
    // run is 1 here, so with both pending the read side keeps one more turn.
    drive(1, 1, 1, 1, 0, 0);
    cyc_check("sa_idle1", E_IDLE);
    drive(1, 1, 1, 1, 1, 0);
    cyc_check("sa_run_rd", E_RDL);
    drive(1, 1, 1, 1, 0, 0);
    cyc_check("sa_idle2", E_IDLE);
    drive(1, 1, 1, 1, 0, 1);
    cyc_check("sa_run_wr", E_WRL);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
